integral_window_builder: RTL
============================

Name: integral_window_builder

Overview:
- Streaming producer of the 20x20 integral-image window consumed by the Haar cascade comparison stage.
- Accepts 8-bit grayscale pixels in raster order over a valid/ready handshake and builds the summed-area table incrementally.
- Presents the full table on INTEGRAL_BUFFER and holds START high until the consumer releases it with NEXT_WINDOW.

Parameters:
- WIN_W, 20, window width in pixels.
- WIN_H, 20, window height in pixels.
- PIX_W, 8, pixel width in bits.
- SUM_W, 32, width of each integral entry.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- PIXEL  input  PIX_W  grayscale pixel, raster order, x fastest.
- PIXEL_VALID  input  1  PIXEL is valid this cycle.
- PIXEL_SOF  input  1  qualified by PIXEL_VALID; this pixel is (0,0) of a new window.
- PIXEL_READY  output  1  block can accept a pixel this cycle.
- NEXT_WINDOW  input  1  consumer has sampled its result; release the window.
- INTEGRAL_BUFFER  output  SUM_W x (WIN_W*WIN_H) unpacked  entry [y*WIN_W+x] = sum of PIXEL over rows 0..y, cols 0..x.
- START  output  1  table complete and stable; consumer evaluates while high.

Behaviour:
- Reset (Reset_n=0 at an edge) has priority over all other inputs, including mid-window. It sets:
  - state=ACCUM; x=y=0; row_sum=0;
  - all INTEGRAL_BUFFER entries=0; START=0; PIXEL_READY=1.
- States:
  - ACCUM: PIXEL_READY=1, START=0.
  - PRESENT: PIXEL_READY=0, START=1.
- Transfer occurs when PIXEL_VALID && PIXEL_READY. Each transfer takes one cycle; full throughput is one pixel per clock.
- On transfer in ACCUM:
  - If PIXEL_SOF=1, the pixel is (0,0) regardless of the current x,y; the partial window is discarded.
  - rs = (x==0 ? 0 : row_sum) + PIXEL, zero-extended to SUM_W.
  - entry[y*WIN_W+x] <= rs + (y==0 ? 0 : entry[(y-1)*WIN_W+x]).
  - row_sum <= rs.
  - x increments. At x==WIN_W-1, x wraps to 0 and y increments.
- Last-pixel transition:
  - The transfer at (WIN_W-1, WIN_H-1) moves the block to PRESENT at the same edge, and x,y return to 0.
  - START is high the cycle after the last accepted pixel (latency 1).
- PRESENT:
  - INTEGRAL_BUFFER is frozen. PIXEL_VALID is ignored; no transfer occurs.
  - NEXT_WINDOW=1 moves the block to ACCUM at the next edge: START=0, PIXEL_READY=1 the following cycle.
  - Entries are not cleared on leaving PRESENT; every entry is overwritten before the next START.
- NEXT_WINDOW in ACCUM is ignored.
- NEXT_WINDOW and PIXEL_VALID asserted together in PRESENT: the transition happens and the pixel is not consumed. The source must hold it, since READY=0.
- Gaps (PIXEL_VALID=0) in ACCUM hold all state.
- PIXEL_SOF without PIXEL_VALID has no effect.
- Arithmetic: max entry = 400*255 = 102000, which fits in 17 bits. No overflow is possible at SUM_W=32; upper bits are always 0.
- START is registered and glitch-free. INTEGRAL_BUFFER is read combinationally by the consumer.

Test Plan:
- Reset, then 400 pixels of value 1 back-to-back with SOF on the first:
  - Each entry[y*20+x] == (x+1)*(y+1); entry[399] == 400.
  - START rises exactly 1 cycle after the 400th transfer; PIXEL_READY=0 while START=1.
- 400 pixels of 255:
  - entry[399] == 102000, entry[19] == 5100, entry[380] == 5100.
  - Then NEXT_WINDOW pulse -> START=0 and READY=1 on the next cycle.
- Ramp PIXEL = x (0..19), random VALID gaps of 0-3 cycles:
  - entry[19] == 190, entry[399] == 3800.
  - Result identical to the gap-free run.
- Send 150 pixels of 7, then SOF pixel, then 399 more pixels of 2:
  - entry[399] == 800; no START after the first 150 pixels.
- Reset_n low for 1 cycle after 250 pixels:
  - All entries 0, START=0, READY=1.
  - A fresh 400-pixel run of value 3 gives entry[399] == 1200.
- In PRESENT, hold PIXEL_VALID=1 with PIXEL=9 and pulse NEXT_WINDOW together with it:
  - Buffer unchanged while START=1.
  - The pixel is first accepted the cycle after START falls, written as entry[0] == 9.

Source files
------------

// File: rtl/integral_window_builder_if.sv
// Pixel stream bundle feeding the integral window builder.
//   PIXEL        grayscale sample, raster order, x fastest
//   PIXEL_VALID  PIXEL carries data this cycle
//   PIXEL_SOF    with PIXEL_VALID: this pixel is (0,0) of a new window
//   PIXEL_READY  sink accepts a pixel this cycle
// master = pixel source, slave = integral_window_builder.
interface integral_window_builder_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] PIXEL;
  logic             PIXEL_VALID;
  logic             PIXEL_SOF;
  logic             PIXEL_READY;

  modport master (
    output PIXEL, PIXEL_VALID, PIXEL_SOF,
    input  PIXEL_READY
  );

  modport slave (
    input  PIXEL, PIXEL_VALID, PIXEL_SOF,
    output PIXEL_READY
  );
endinterface

// File: rtl/integral_window_builder.sv
// Streaming builder of a WIN_W x WIN_H summed-area table for the Haar
// cascade comparison stage.
//   Clk              system clock, rising edge
//   Reset_n          synchronous active-low reset
//   pix              pixel stream (slave side of integral_window_builder_if)
//   NEXT_WINDOW      consumer done with the presented table
//   INTEGRAL_BUFFER  entry [y*WIN_W+x] = sum of pixels rows 0..y, cols 0..x
//   START            table complete and frozen while high
// One pixel per clock is accumulated in ACCUM; after the last pixel the
// table is held in PRESENT until NEXT_WINDOW.
module integral_window_builder #(
  parameter int WIN_W = 20,
  parameter int WIN_H = 20,
  parameter int PIX_W = 8,
  parameter int SUM_W = 32
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  integral_window_builder_if.slave pix,
  input  logic                 NEXT_WINDOW,
  output logic [SUM_W-1:0]     INTEGRAL_BUFFER [WIN_W*WIN_H],
  output logic                 START
);

  localparam int N  = WIN_W * WIN_H;
  localparam int XW = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam int YW = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ACCUM   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [SUM_W-1:0]  row_sum_q, row_sum_d;
  logic [SUM_W-1:0]  buf_q [N];

  logic              xfer;
  logic [XW-1:0]     x_eff;
  logic [YW-1:0]     y_eff;
  logic [SUM_W-1:0]  rs;
  logic [SUM_W-1:0]  above;
  logic [IW-1:0]     wr_idx;
  logic [SUM_W-1:0]  wr_val;
  logic              wr_en;

  // SOF forces the write position to (0,0) so the new window starts
  // cleanly on top of whatever partial window was in progress.
  always_comb begin
    xfer   = pix.PIXEL_VALID && (state_q == ACCUM);
    x_eff  = pix.PIXEL_SOF ? '0 : x_q;
    y_eff  = pix.PIXEL_SOF ? '0 : y_q;
    rs     = ((x_eff == '0) ? '0 : row_sum_q) + SUM_W'(pix.PIXEL);
    wr_idx = IW'(y_eff) * IW'(WIN_W) + IW'(x_eff);
    above  = (y_eff == '0) ? '0 : buf_q[wr_idx - IW'(WIN_W)];
    wr_val = rs + above;
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    row_sum_d = row_sum_q;
    wr_en     = 1'b0;
    case (state_q)
      ACCUM: begin
        if (xfer) begin
          wr_en     = 1'b1;
          row_sum_d = rs;
          if (x_eff == XW'(WIN_W - 1)) begin
            x_d = '0;
            if (y_eff == YW'(WIN_H - 1)) begin
              y_d     = '0;
              state_d = PRESENT;
            end else begin
              y_d = y_eff + YW'(1);
            end
          end else begin
            x_d = x_eff + XW'(1);
            y_d = y_eff;
          end
        end
      end
      PRESENT: begin
        if (NEXT_WINDOW) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= ACCUM;
      x_q       <= '0;
      y_q       <= '0;
      row_sum_q <= '0;
      for (int unsigned i = 0; i < N; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      row_sum_q <= row_sum_d;
      if (wr_en) buf_q[wr_idx] <= wr_val;
    end
  end

  // Both outputs decode the registered state, so they never glitch.
  assign pix.PIXEL_READY  = (state_q == ACCUM);
  assign START            = (state_q == PRESENT);
  assign INTEGRAL_BUFFER  = buf_q;

endmodule
